receive_beamformer: RTL and testbench

//  Receive-side counterpart of the transmit beamformer: delay-and-sum over NUM_RECEIVERS ADC channels,

---
 rtl/sonic_sight_pkg.sv | 33 +++
 rtl/rx_delay_line.sv | 57 +++++
 rtl/receive_beamformer.sv | 204 ++++++++++++++++++++
 tb/tb_receive_beamformer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_sight_pkg.sv
// sonic_sight_pkg: types and constants shared by the transmit and receive paths.
// Holds the steering-delay helper used to turn an angle code into element delays.
package sonic_sight_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    LISTEN,
    DONE
  } rx_state_t;

  localparam int SIN_WIDTH = 17;
  localparam int SPEED_OF_SOUND_MM_S = 343000;
  localparam int ELEMENT_SPACING_MM = 9;

  // (per_elem * k * sin) >> frac_bits, clamped to max_d
  function automatic int unsigned steer_delay(
    input int unsigned per_elem,
    input int unsigned k,
    input logic [31:0] sin_v,
    input int unsigned frac_bits,
    input int unsigned max_d
  );
    logic [63:0] p;
    p = 64'(per_elem) * 64'(k) * 64'(sin_v);
    p = p >> frac_bits;
    if (p > 64'(max_d)) begin
      return max_d;
    end
    return p[31:0];
  endfunction

endpackage

// File: rtl/rx_delay_line.sv
// rx_delay_line: one receive channel's circular delay buffer and tap register.
// The fill counter keeps the tap at zero until the delayed sample is real data.
module rx_delay_line #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int DELAY_DEPTH = 64,
  localparam int PW = $clog2(DELAY_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [PW-1:0]                  wr_ptr,
  input  logic [PW-1:0]                  delay,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic signed [SAMPLE_WIDTH-1:0] tap
);

  logic signed [SAMPLE_WIDTH-1:0] mem [DELAY_DEPTH];
  logic [PW:0]   fill;
  logic [PW-1:0] rd_ptr;
  logic          have;

  assign rd_ptr = wr_ptr - delay;
  assign have   = fill >= {1'b0, delay};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (wr_en && fill != (PW+1)'(DELAY_DEPTH)) begin
      fill <= fill + 1'b1;
    end
  end

  // zero delay taps the sample being written this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap <= '0;
    end else if (wr_en) begin
      if (!have) begin
        tap <= '0;
      end else if (delay == '0) begin
        tap <= sample;
      end else begin
        tap <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/receive_beamformer.sv
// receive_beamformer: delay-and-sum receive beam with echo time-of-flight.
// Define RX_BEAMFORMER_PEAK_EN to build the per-listen peak magnitude tracker.
module receive_beamformer
  import sonic_sight_pkg::*;
#(
  parameter int NUM_RECEIVERS  = 2,
  parameter int SAMPLE_WIDTH   = 12,
  parameter int SIN_WIDTH      = 17,
  parameter int DELAY_PER_ELEM = 26,
  parameter int DELAY_DEPTH    = 64,
  parameter int BLANK_CYCLES   = 524288,
  parameter int MAX_TOF_CYCLES = 16777216,
  parameter int THRESHOLD      = 1024,
  localparam int SUM_W = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS) + 1
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic [SIN_WIDTH-1:0]                  sin_value,
  input  logic                                  sign_bit,
  input  logic                                  burst_start,
  input  logic                                  sample_valid,
  input  logic [NUM_RECEIVERS*SAMPLE_WIDTH-1:0] samples,
  output logic signed [SUM_W-1:0]               sum_out,
  output logic                                  sum_valid,
  output logic                                  echo_valid,
  output logic                                  echo_timeout,
  output logic [31:0]                           tof_cycles,
  output logic [SUM_W-1:0]                      peak_mag
);

  localparam int PW    = $clog2(DELAY_DEPTH);
  localparam int MAG_W = SUM_W + 1;

  rx_state_t state, state_nx;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] delay_q  [NUM_RECEIVERS];
  logic [PW-1:0] delay_nx [NUM_RECEIVERS];
  logic signed [SAMPLE_WIDTH-1:0] tap [NUM_RECEIVERS];

  logic                    v1;
  logic [31:0]             tof;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [MAG_W-1:0] sum_x;
  logic [MAG_W-1:0]        mag;
  logic                    hit;
  logic                    tmo;
  logic                    echo_set;

  // sign_bit=1 delays the rightmost element most
  always_comb begin
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      delay_nx[i] = PW'(steer_delay(
        DELAY_PER_ELEM,
        sign_bit ? i : NUM_RECEIVERS - 1 - i,
        32'(sin_value),
        SIN_WIDTH - 1,
        DELAY_DEPTH - 1));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_RECEIVERS; i++) begin
        delay_q[i] <= '0;
      end
    end else if (burst_start) begin
      for (int i = 0; i < NUM_RECEIVERS; i++) begin
        delay_q[i] <= delay_nx[i];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
    end else if (sample_valid) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RECEIVERS; g++) begin : g_ch
    rx_delay_line #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .DELAY_DEPTH (DELAY_DEPTH)
    ) u_dl (
      .clk   (clk_in),
      .rst   (rst_in),
      .clear (burst_start),
      .wr_en (sample_valid),
      .wr_ptr(wr_ptr),
      .delay (delay_q[g]),
      .sample(samples[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
      .tap   (tap[g])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      sum_c = sum_c + SUM_W'(tap[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      v1        <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      v1        <= sample_valid;
      sum_valid <= v1;
      if (v1) begin
        sum_out <= sum_c;
      end
    end
  end

  // one extra bit so the most negative sum has a magnitude
  always_comb begin
    sum_x = MAG_W'(sum_out);
    mag   = (sum_x < 0) ? MAG_W'(-sum_x) : MAG_W'(sum_x);
  end

  assign hit = sum_valid && (mag >= MAG_W'(THRESHOLD));
  assign tmo = tof == 32'(MAX_TOF_CYCLES - 1);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tof <= '0;
    end else if (burst_start) begin
      tof <= '0;
    end else if ((state == BLANK || state == LISTEN) && tof != '1) begin
      tof <= tof + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    echo_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (burst_start) state_nx = BLANK;
      end
      BLANK: begin
        if (burst_start) begin
          state_nx = BLANK;
        end else if (tof == 32'(BLANK_CYCLES - 1)) begin
          state_nx = LISTEN;
        end
      end
      LISTEN: begin
        if (burst_start) begin
          state_nx = BLANK;
        end else if (hit || tmo) begin
          state_nx = DONE;
          echo_set = 1'b1;
        end
      end
      DONE: begin
        state_nx = burst_start ? BLANK : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // a detection in the timeout cycle is reported as a detection
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      echo_valid   <= 1'b0;
      echo_timeout <= 1'b0;
      tof_cycles   <= '0;
    end else begin
      echo_valid   <= echo_set;
      echo_timeout <= echo_set && !hit;
      if (echo_set) begin
        tof_cycles <= hit ? tof : 32'(MAX_TOF_CYCLES);
      end
    end
  end

`ifdef RX_BEAMFORMER_PEAK_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      peak_mag <= '0;
    end else if (burst_start) begin
      peak_mag <= '0;
    end else if (state == LISTEN && sum_valid && mag > MAG_W'(peak_mag)) begin
      peak_mag <= mag[SUM_W-1:0];
    end
  end
`else
  assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_receive_beamformer.sv
// tb_receive_beamformer: directed checks of steering, blanking, threshold,
// timeout, restart and reset using hand-computed results.
module tb_receive_beamformer;

  localparam int SW    = 12;
  localparam int SUM_W = 14;
`ifdef RX_BEAMFORMER_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic [16:0]             sin_value;
  logic                    sign_bit;
  logic                    burst_start;
  logic                    sample_valid;
  logic [2*SW-1:0]         samples;
  logic signed [SUM_W-1:0] sum_out;
  logic                    sum_valid;
  logic                    echo_valid;
  logic                    echo_timeout;
  logic [31:0]             tof_cycles;
  logic [SUM_W-1:0]        peak_mag;

  receive_beamformer #(
    .NUM_RECEIVERS (2),
    .SAMPLE_WIDTH  (SW),
    .SIN_WIDTH     (17),
    .DELAY_PER_ELEM(26),
    .DELAY_DEPTH   (64),
    .BLANK_CYCLES  (100),
    .MAX_TOF_CYCLES(1000),
    .THRESHOLD     (1024)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sin_value   (sin_value),
    .sign_bit    (sign_bit),
    .burst_start (burst_start),
    .sample_valid(sample_valid),
    .samples     (samples),
    .sum_out     (sum_out),
    .sum_valid   (sum_valid),
    .echo_valid  (echo_valid),
    .echo_timeout(echo_timeout),
    .tof_cycles  (tof_cycles),
    .peak_mag    (peak_mag)
  );

  always #5 clk_in = ~clk_in;

  int edge_n = 0;
  always @(posedge clk_in) edge_n <= edge_n + 1;

  int n_echo = 0;
  int e_tof, e_edge;
  logic e_to;
  logic [SUM_W-1:0] e_peak;
  logic signed [SUM_W-1:0] sums[$];

  always @(negedge clk_in) begin
    if (echo_valid) begin
      n_echo++;
      e_tof  = int'(tof_cycles);
      e_to   = echo_timeout;
      e_edge = edge_n;
      e_peak = peak_mag;
    end
    if (sum_valid) sums.push_back(sum_out);
  end

  int n_chk = 0;
  int n_err = 0;
  int b_edge, s_edge, n0, other;

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pk(input int v);
    return PK ? v : 0;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic burst(input logic [16:0] s, input logic sg);
    sin_value   = s;
    sign_bit    = sg;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    b_edge      = edge_n;
  endtask

  task automatic strobe(input int a, input int b);
    samples      = {b[SW-1:0], a[SW-1:0]};
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    samples      = '0;
    s_edge       = edge_n;
  endtask

  initial begin
    rst_in       = 1'b1;
    sin_value    = '0;
    sign_bit     = 1'b0;
    burst_start  = 1'b0;
    sample_valid = 1'b0;
    samples      = '0;
    wait_cycles(2);
    check("rst_sum", sum_out, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_echo", echo_valid, 0);
    check("rst_tof", tof_cycles, 0);
    rst_in = 1'b0;
    tick();

    // blanking: sum in BLANK ignored, first LISTEN cycle detects
    burst(17'd0, 1'b0);
    wait_cycles(48);
    strobe(1000, 1000);
    tick();
    check("blank_sum", sum_out, 2000);
    check("blank_sum_valid", sum_valid, 1);
    wait_cycles(47);
    strobe(1000, 1000);
    strobe(600, 600);
    tick();
    check("bcast_sum", sum_out, 1200);
    wait_cycles(2);
    check("blank_echo_cnt", n_echo, 1);
    check("blank_tof", e_tof, 100);
    check("blank_echo_edge", e_edge - b_edge, 101);
    check("blank_to", e_to, 0);
    check("blank_peak", e_peak, pk(1200));

    // negative sum in IDLE; threshold is inclusive on |sum|
    strobe(-600, -600);
    tick();
    check("neg_sum", sum_out, -1200);
    wait_cycles(3);
    check("idle_no_echo", n_echo, 1);
    burst(17'd0, 1'b0);
    wait_cycles(120);
    n0 = n_echo;
    strobe(511, 512);
    wait_cycles(3);
    check("sub_thr", n_echo, n0);
    strobe(-512, -512);
    wait_cycles(3);
    check("thr_echo", n_echo, n0 + 1);
    check("thr_tof", e_tof, 126);
    check("thr_peak", e_peak, pk(1024));

    // steering right-delayed: two separate 800 peaks, then timeout
    burst(17'd65536, 1'b1);
    wait_cycles(110);
    sums.delete();
    n0 = n_echo;
    for (int i = 0; i < 41; i++) begin
      strobe(i == 0 ? 800 : 0, i == 0 ? 800 : 0);
    end
    wait_cycles(2);
    check("steer_n", sums.size(), 41);
    check("steer_p0", sums[0], 800);
    check("steer_p26", sums[26], 800);
    other = 0;
    for (int i = 1; i < sums.size(); i++) begin
      if (i != 26) other += (sums[i] < 0) ? -int'(sums[i]) : int'(sums[i]);
    end
    check("steer_rest", other, 0);
    check("steer_no_echo", n_echo, n0);
    for (int i = 0; i < 1200 && n_echo == n0; i++) tick();
    check("tmo_echo", n_echo, n0 + 1);
    check("tmo_flag", e_to, 1);
    check("tmo_tof", e_tof, 1000);
    check("tmo_edge", e_edge - b_edge, 1000);
    check("tmo_peak", e_peak, pk(800));

    // left steering: ch0 leads ch1 by the 26-sample delay -> aligned 1600
    burst(17'd65536, 1'b0);
    wait_cycles(110);
    sums.delete();
    n0 = n_echo;
    for (int i = 0; i < 31; i++) begin
      strobe(i == 0 ? 800 : 0, i == 26 ? 800 : 0);
    end
    wait_cycles(2);
    check("align_p0", sums[0], 0);
    check("align_p26", sums[26], 1600);
    check("align_echo", n_echo, n0 + 1);
    check("align_to", e_to, 0);
    check("align_tof", e_tof, 138);
    check("align_peak", e_peak, pk(1600));

    // restart during LISTEN: no echo for the aborted listen
    burst(17'd0, 1'b0);
    wait_cycles(110);
    strobe(700, 0);
    wait_cycles(2);
    check("peak_track", peak_mag, pk(700));
    n0 = n_echo;
    burst(17'd0, 1'b0);
    check("peak_clear", peak_mag, 0);
    wait_cycles(110);
    strobe(-512, -512);
    wait_cycles(3);
    check("restart_echo", n_echo, n0 + 1);
    check("restart_tof", e_tof, 112);

    // async reset mid-listen
    burst(17'd0, 1'b0);
    wait_cycles(110);
    strobe(300, 300);
    tick();
    check("pre_rst_sum", sum_out, 600);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_sum", sum_out, 0);
    check("arst_tof", tof_cycles, 0);
    check("arst_peak", peak_mag, 0);
    check("arst_echo", echo_valid, 0);
    tick();
    rst_in = 1'b0;
    n0 = n_echo;
    wait_cycles(1100);
    check("arst_no_echo", n_echo, n0);
    check("arst_tof_hold", tof_cycles, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
